mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Serialises accesses with a small FSM, fair round-robin on contention, and a fixed-latency memory read pipeline with per-requester response routing.
- Sits between the core control FSM and the word-addressed memory array.

Parameters:
- ADDR_WIDTH, 32, byte-address width of requester ports.
- DATA_WIDTH, 32, data width; must be 32.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle fetch response strobe.
- if_rdata  out  DATA_WIDTH  fetched word; valid with if_rvalid.
- d_req  in  1  data request; held with fields until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle load data / store ack strobe.
- d_rdata  out  DATA_WIDTH  load data; 0 for store acks.
- d_err  out  1  error flag, valid with d_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  4  memory byte enables.
- mem_addr  out  ADDR_WIDTH-2  word address = addr[ADDR_WIDTH-1:2].
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - All outputs 0; FSM = IDLE; wait counter = 0.
  - last_owner = D, so IF wins the first tie.
  - Asserting reset mid-access aborts it and produces no rvalid. A write already strobed to memory is not undone.
- States: IDLE, ISSUE, WAIT, RESP.
- Grant (combinational):
  - Asserted only in IDLE or RESP, for exactly one requester.
  - Only IF requesting -> if_gnt. Only D requesting -> d_gnt.
  - Both requesting -> grant the requester that is not last_owner. last_owner updates on every grant.
  - if_gnt and d_gnt are never both 1.
- On grant, the command is registered: owner, addr, we, wdata, wstrb (IF: we=0, wstrb=0). Next state = ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/mem_wstrb/mem_addr/mem_wdata driven from registers.
  - Counter loads MEM_LATENCY-1. -> WAIT.
- WAIT:
  - Counter decrements each cycle. At 0, mem_rdata is captured (loads/fetches only). -> RESP.
  - mem_en=0 throughout.
- RESP (1 cycle):
  - Owner's rvalid=1 with registered data; store ack drives rdata=0, d_err=0.
  - If a request is present, grant it and go to ISSUE; otherwise -> IDLE.
- Timing:
  - Grant at cycle T -> rvalid at T+2+MEM_LATENCY.
  - Sustained throughput is one access per 2+MEM_LATENCY cycles.
- Addressing: addr[1:0] is ignored for memory addressing (word-aligned access).
- Requests arriving in ISSUE/WAIT are not granted. The requester holds req; no request is dropped.
- A req deasserted before grant is withdrawn, with no side effects.

Optional Feature:
- Macro: MEM_PORT_ARBITER_MISALIGN_CHECK_EN.
- With the macro: a granted D access with d_addr[1:0] != 0 skips ISSUE/WAIT; mem_en is never asserted. It goes IDLE/RESP -> RESP next cycle with d_rvalid=1, d_err=1, d_rdata=0.
- Without the macro: d_err is tied 0, and misaligned addresses access the containing word normally.

Test Plan:
- Single fetch: if_req=1, if_addr=0x8, MEM_LATENCY=1, mem word 2 = 0x00200093 -> if_gnt at T, mem_en/mem_addr=2 at T+1, if_rvalid with if_rdata=0x00200093 at T+3.
- Store then load: D store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> mem_we=1, mem_addr=4, d_rvalid with d_rdata=0. A following load of 0x10 -> d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held together from reset for 4 grants -> grant order IF, D, IF, D; never both gnt; each response routed to its owner only.
- Back-to-back: D request pending during RESP of an IF access -> d_gnt in that same RESP cycle; next mem_en one cycle later; busy stays 1.
- Reset mid-access: drop reset to 0 during WAIT -> all outputs 0 immediately, no rvalid afterwards. After release, a new fetch completes normally at T+3.
- Misalign (macro on): d_addr=0x13 load -> no mem_en, d_rvalid=1 and d_err=1 one cycle after d_gnt. Macro off: word 4 is read and d_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/D sharing of one fixed-latency memory; define MEM_PORT_ARBITER_MISALIGN_CHECK_EN to error misaligned D accesses
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic owner_d, last_d, we_q, can_gnt, pick_d, gnt, mis, err_q, unused_lsbs;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic [2:0] cnt;
  assign unused_lsbs = ^{if_addr[1:0], d_addr[1:0]};
  // grants are suppressed while reset is held so every output reads 0
  assign can_gnt = reset && (state == IDLE || state == RESP);
  assign pick_d  = d_req && (!if_req || !last_d);
  assign if_gnt  = can_gnt && if_req && !pick_d;
  assign d_gnt   = can_gnt && pick_d;
  assign gnt     = if_gnt || d_gnt;
`ifdef MEM_PORT_ARBITER_MISALIGN_CHECK_EN
  assign mis = d_gnt && d_addr[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    state_nx = (state == ISSUE) ? WAIT :
               (state == WAIT)  ? (cnt == 3'd0 ? RESP : WAIT) :
               gnt ? (mis ? RESP : ISSUE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt) begin
        owner_d <= d_gnt;
        last_d  <= d_gnt;
        we_q    <= d_gnt && d_we;
        addr_q  <= d_gnt ? d_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
        wdata_q <= d_gnt ? d_wdata : '0;
        wstrb_q <= d_gnt ? d_wstrb : '0;
        rdata_q <= '0;
        err_q   <= mis;
      end
      if (state == ISSUE) cnt <= 3'(MEM_LATENCY - 1);
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd0 && !we_q) rdata_q <= mem_rdata;
    end
  end
  assign busy      = state != IDLE;
  assign mem_en    = state == ISSUE;
  assign mem_we    = mem_en && we_q;
  assign mem_wstrb = mem_en ? wstrb_q : 4'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rvalid = state == RESP && !owner_d;
  assign d_rvalid  = state == RESP && owner_d;
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid ? rdata_q : '0;
  assign d_err     = d_rvalid && err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of fetch, store/load, contention, back-to-back, reset abort and misalign
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_wstrb = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic [29:0] mem_addr;
  logic [31:0] mem [64];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always @(posedge clk) begin
    if (!reset) mem[2] <= 32'h00200093;
    else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_wstrb[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp);
    cyc;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb; end
    else begin if_req = 1; if_addr = addr; end
    @(negedge clk);
    check("gnt", is_d ? d_gnt : if_gnt, 1);
    check("gnt_other", is_d ? if_gnt : d_gnt, 0);
    cyc;
    if_req = 0; d_req = 0;
    @(negedge clk);
    check("mem_en", mem_en, 1);
    check("mem_addr", mem_addr, addr >> 2);
    check("mem_we", mem_we, we);
    if (we) check("mem_wdata", mem_wdata, wdata);
    cyc;
    @(negedge clk);
    check("wait_no_rvalid", if_rvalid | d_rvalid | mem_en, 0);
    cyc;
    @(negedge clk);
    check("rvalid", is_d ? d_rvalid : if_rvalid, 1);
    check("rvalid_other", is_d ? if_rvalid : d_rvalid, 0);
    check("rdata", is_d ? d_rdata : if_rdata, exp);
    check("d_err", d_err, 0);
    cyc;
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask
  initial begin
    int g, r, gc[4];
    logic [3:0] who;
    bit both, route_bad, b2b_bad, bubble, en_bad, pg;
    @(negedge clk);
    if_req = 1;
    #1;
    check("rst_gnt", {30'b0, if_gnt, d_gnt}, 0);
    check("rst_busy", {busy, mem_en, if_rvalid, d_rvalid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    if_req = 0;
    cyc;
    cyc;
    reset = 1;
    access(0, 0, 32'h8, 0, 0, 32'h00200093);
    access(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    access(1, 0, 32'h10, 0, 0, 32'hDEADBEEF);
`ifdef MEM_PORT_ARBITER_MISALIGN_CHECK_EN
    cyc;
    d_req = 1; d_we = 0; d_addr = 32'h13;
    @(negedge clk);
    check("mis_gnt", d_gnt, 1);
    cyc;
    d_req = 0;
    @(negedge clk);
    check("mis_no_en", mem_en, 0);
    check("mis_rvalid", d_rvalid, 1);
    check("mis_err", d_err, 1);
    check("mis_rdata", d_rdata, 0);
    cyc;
    @(negedge clk);
    check("mis_idle", busy, 0);
`else
    access(1, 0, 32'h13, 0, 0, 32'hDEADBEEF);
`endif
    cyc;
    reset = 0;
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h10;
    @(negedge clk);
    check("rst_hold_gnt", {30'b0, if_gnt, d_gnt}, 0);
    cyc;
    reset = 1;
    g = 0; r = 0; who = 0; both = 0; route_bad = 0; b2b_bad = 0; bubble = 0; en_bad = 0; pg = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both = 1;
      if (g >= 1 && r < 4 && !busy) bubble = 1;
      if (pg && !mem_en) en_bad = 1;
      pg = 0;
      if (if_rvalid || d_rvalid) begin
        if ((if_rvalid && d_rvalid) || r >= 4 || d_rvalid != who[r]) route_bad = 1;
        r++;
      end
      if (if_gnt || d_gnt) begin
        if (g < 4) begin who[g] = d_gnt; gc[g] = c; end
        if (g > 0 && !(if_rvalid || d_rvalid)) b2b_bad = 1;
        g++;
        pg = 1;
      end
      cyc;
      if (g >= 4) begin if_req = 0; d_req = 0; end
    end
    check("rr_grants", g, 4);
    check("rr_order", {28'b0, who}, 32'b1010);
    check("rr_never_both", both, 0);
    check("rr_routing", route_bad, 0);
    check("rr_resp_count", r, 4);
    check("b2b_in_resp", b2b_bad, 0);
    check("b2b_gap", gc[1] - gc[0], 3);
    check("b2b_mem_en", en_bad, 0);
    check("b2b_busy", bubble, 0);
    cyc;
    if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    check("abort_gnt", if_gnt, 1);
    cyc;
    if_req = 0;
    cyc;
    reset = 0;
    #1;
    check("abort_outputs", {busy, mem_en, if_rvalid, d_rvalid, if_gnt, d_gnt}, 0);
    @(negedge clk);
    check("abort_no_rvalid", {if_rvalid, d_rvalid}, 0);
    cyc;
    @(negedge clk);
    check("abort_still_quiet", {busy, if_rvalid, d_rvalid}, 0);
    cyc;
    reset = 1;
    access(0, 0, 32'h8, 0, 0, 32'h00200093);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
